// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional abort input enabled by defining MDU_CANCEL_EN.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MDU_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   src_a;
    logic [WIDTH-1:0]   src_b;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               abort;
    logic               accept;
    logic               signed_op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_borrow;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef MDU_CANCEL_EN
    assign abort = cancel;
`else
    assign abort = 1'b0;
`endif

    // op[2]=0 selects MULT..DIVU; op[1] picks divide, op[0]=0 means signed.
    assign accept    = (state == IDLE) && start && !op[2];
    assign signed_op = ~op[0];
    assign sign_a    = signed_op & a[WIDTH-1];
    assign sign_b    = signed_op & b[WIDTH-1];
    assign a_mag     = sign_a ? -a : a;
    assign b_mag     = sign_b ? -b : b;

    // Multiply: add the multiplicand into the upper half, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (src_b[0] ? {1'b0, src_a} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: partial remainder in the upper half, quotient bits enter at the bottom.
    assign div_shift  = {acc[2*WIDTH-1:WIDTH], src_a[WIDTH-1]};
    assign div_borrow = div_shift < {1'b0, src_b};
    assign div_rem    = div_borrow ? div_shift[WIDTH-1:0] : WIDTH'(div_shift - {1'b0, src_b});
    assign div_next   = {div_rem, acc[WIDTH-2:0], ~div_borrow};

    assign prod_fix = neg_res ? -acc : acc;
    assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cnt == CNT_W'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort && (state != IDLE)) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            src_a   <= '0;
            src_b   <= '0;
            acc     <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state  <= state_next;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        src_a   <= a_mag;
                        src_b   <= b_mag;
                        acc     <= '0;
                        cnt     <= CNT_W'(WIDTH);
                        is_div  <= op[1];
                        // A zero divisor keeps the all-ones quotient unsigned.
                        neg_res <= (sign_a ^ sign_b) && !(op[1] && (b == '0));
                        neg_rem <= op[1] & sign_a;
                    end else if (start && (op == OP_MTHI)) begin
                        hi_q <= a;
                    end else if (start && (op == OP_MTLO)) begin
                        lo_q <= a;
                    end
                end
                CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (is_div) begin
                        acc   <= div_next;
                        src_a <= src_a << 1;
                    end else begin
                        acc   <= mul_next;
                        src_b <= src_b >> 1;
                    end
                end
                FIX: begin
                    if (!abort) begin
                        if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-level reference model plus directed vectors.
// Define MDU_CANCEL_EN to also exercise the abort input.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
`ifdef MDU_CANCEL_EN
        .cancel (cancel),
`endif
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an op, straight from signed/unsigned arithmetic: {hi, lo}.
    function automatic logic [63:0] mdl(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] res;
        sx = $signed(x);
        sy = $signed(y);
        res = '0;
        case (o)
            3'd0: res = 64'(sx * sy);
            3'd1: res = {32'h0, x} * {32'h0, y};
            3'd2: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Reference model: 33-cycle latency after acceptance, results queued in exp_q.
    logic [63:0] exp_q[$];
    int          m_cnt  = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
`ifdef MDU_CANCEL_EN
                if (cancel) begin
                    m_cnt = 0;
                    exp_q.delete();
                end else
`endif
                begin
                    m_cnt--;
                    if (m_cnt == 0 && exp_q.size() > 0) begin
                        {m_hi, m_lo} = exp_q.pop_front();
                        m_done = 1'b1;
                    end
                end
            end else if (start) begin
                if (op <= 3'd3) begin
                    exp_q.push_back(mdl(op, a, b));
                    m_cnt = 33;
                end else if (op == 3'd4) m_hi = a;
                else if (op == 3'd5) m_lo = a;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_busy", {31'b0, busy}, {31'b0, (m_cnt > 0)});
            chk("model_done", {31'b0, done}, {31'b0, m_done});
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    // Drive a request for one cycle, then scramble the operands.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'($urandom_range(0, 7));
        a      = $urandom;
        b      = $urandom;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input int poke_at);
        int n;
        issue(o, x, y);
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == poke_at) begin
                start = 1'b1;
                op    = 3'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("latency", 32'(n), 32'd33);
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("result_hi", hi, eh);
        chk("result_lo", lo, el);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        check_en = 1'b1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);

        // Back-to-back sequence: each call starts in the cycle done is high.
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        do_op(3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        do_op(3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0);
        do_op(3'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
        do_op(3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         0);
        do_op(3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 0);
        do_op(3'd3, 32'd1000,      32'd7,         32'd6,         32'd142,       10);

        issue(3'd4, 32'h1234_5678, 32'h0);
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        chk("mthi_done", {31'b0, done}, 32'd0);
        issue(3'd6, 32'hDEAD_BEEF, 32'h1);
        chk("reserved_busy", {31'b0, busy}, 32'd0);
        chk("reserved_hi", hi, 32'h1234_5678);

        issue(3'd0, 32'd3, 32'd5);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_busy", {31'b0, busy}, 32'd0);
        chk("midreset_done", {31'b0, done}, 32'd0);
        chk("midreset_hi", hi, 32'h0);
        chk("midreset_lo", lo, 32'h0);
        repeat (40) begin
            @(negedge clk);
            chk("midreset_no_done", {31'b0, done}, 32'd0);
        end

`ifdef MDU_CANCEL_EN
        issue(3'd5, 32'd5, 32'd0);
        chk("mtlo_lo", lo, 32'd5);
        issue(3'd3, 32'd9, 32'd2);
        repeat (19) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", {31'b0, busy}, 32'd0);
        chk("cancel_done", {31'b0, done}, 32'd0);
        chk("cancel_lo", lo, 32'd5);
        repeat (3) @(negedge clk);
        cancel = 1'b1;
        do_op(3'd3, 32'd9, 32'd2, 32'd1, 32'd4, 0);
`endif

        @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
